// File: rtl/cs_y_collector.sv
// rtl/cs_y_collector.sv - CS smoother output collector: warm-up skip, Y capture FIFO, count and checksum
module cs_y_collector #(
    parameter int WARMUP = 9,
    parameter int N_OUT  = 1992,
    parameter int DEPTH  = 8,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    Y,
    output logic [9:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [CW-1:0] count,
    output logic [CW-1:0] checksum,
    output logic          overflow,
    output logic          done
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = $clog2(WARMUP + 1);
    localparam int SW = $clog2(N_OUT + 1);

    typedef enum logic [1:0] {WARM, CAPT, DONE} state_t;

    state_t        state;
    logic [WW-1:0] warm_cnt;
    logic [SW-1:0] smp_cnt;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
    logic [9:0]    mem [DEPTH];
    logic [9:0]    head_next;
    logic          full, push_req, pop, accept, last_smp, finishing;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req  = (state == CAPT);
    assign pop       = dout_valid & dout_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign accept    = push_req && (!full || pop);
    assign wr_next   = wr_ptr + PW'(accept);
    assign rd_next   = rd_ptr + PW'(pop);
    assign last_smp  = (smp_cnt == SW'(N_OUT - 1));
    assign finishing = (state == DONE) || (push_req && last_smp);

    // Next head: the incoming Y when it lands directly at the new read slot.
    always_comb begin
        head_next = mem[rd_next[AW-1:0]];
        if (accept && (rd_next == wr_ptr)) head_next = Y;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= Y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WARM;
            warm_cnt   <= '0;
            smp_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            count      <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                WARM: begin
                    warm_cnt <= warm_cnt + WW'(1);
                    if (warm_cnt == WW'(WARMUP - 1)) state <= CAPT;
                end
                CAPT: begin
                    smp_cnt <= smp_cnt + SW'(1);
                    if (last_smp) state <= DONE;
                end
                default: state <= DONE;
            endcase

            if (accept) begin
                if (count != {CW{1'b1}}) count <= count + CW'(1);
                checksum <= checksum + CW'(Y);
            end else if (push_req) begin
                overflow <= 1'b1;
            end

            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            // Output registers load from the post-edge FIFO state so dout is registered.
            dout_valid <= (wr_next != rd_next);
            if (wr_next != rd_next) dout <= head_next;
            done       <= finishing && (wr_next == rd_next);
        end
    end
endmodule

// File: tb/tb_cs_y_collector.sv
// tb/tb_cs_y_collector.sv - self-checking bench for cs_y_collector
module tb_cs_y_collector;
    localparam int WARMUP = 9;
    localparam int N_OUT  = 1992;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        reset, dout_ready, dout_valid, overflow, done;
    logic [9:0]  y, dout;
    logic [15:0] count, checksum;

    logic        reset4, ready4, valid4, overflow4, done4;
    logic [9:0]  y4, dout4;
    logic [15:0] count4, checksum4;

    int checks = 0;
    int failures = 0;

    // Reference model state (main instance)
    int          m_edges, m_taken, m_count, m_sum;
    int          m_q[$];
    int          m_dout;
    bit          m_ovf;

    typedef struct {
        bit         rst;
        logic [9:0] yin;
        bit         rdy;
        bit         exp_valid;
        int         exp_dout;
        int         exp_count;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    cs_y_collector #(.WARMUP(WARMUP), .N_OUT(N_OUT), .DEPTH(DEPTH), .CW(16)) dut (
        .clk(clk), .reset(reset), .Y(y), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .count(count), .checksum(checksum),
        .overflow(overflow), .done(done)
    );

    cs_y_collector #(.WARMUP(WARMUP), .N_OUT(4), .DEPTH(DEPTH), .CW(16)) dut4 (
        .clk(clk), .reset(reset4), .Y(y4), .dout(dout4), .dout_valid(valid4),
        .dout_ready(ready4), .count(count4), .checksum(checksum4),
        .overflow(overflow4), .done(done4)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input int yin, input bit rdy);
        bit pop, cap;
        if (rst) begin
            m_edges = 0; m_taken = 0; m_count = 0; m_sum = 0; m_ovf = 0; m_dout = 0;
            m_q.delete();
            return;
        end
        m_edges++;
        pop = (m_q.size() > 0) && rdy;
        cap = (m_edges >= WARMUP + 1) && (m_taken < N_OUT);
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            m_taken++;
            if (m_q.size() < DEPTH) begin
                m_q.push_back(yin);
                if (m_count < 65535) m_count++;
                m_sum = (m_sum + yin) % 65536;
            end else begin
                m_ovf = 1;
            end
        end
        if (m_q.size() > 0) m_dout = m_q[0];
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(reset, int'(y), dout_ready);
        #1;
        chk("m_valid", dout_valid, m_q.size() > 0);
        chk("m_dout", dout, m_dout);
        chk("m_count", count, m_count);
        chk("m_checksum", checksum, m_sum);
        chk("m_overflow", overflow, m_ovf);
        chk("m_done", done, (m_taken == N_OUT) && (m_q.size() == 0));
    endtask

    task automatic warm(input bit rdy);
        reset = 1; step();
        reset = 0; dout_ready = rdy; y = 10'h3FF;
        for (int i = 0; i < WARMUP; i++) step();
    endtask

    task automatic run_table();
        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst; y = tbl[i].yin; dout_ready = tbl[i].rdy;
            step();
            chk("tbl_valid", dout_valid, tbl[i].exp_valid);
            chk("tbl_dout", dout, tbl[i].exp_dout);
            chk("tbl_count", count, tbl[i].exp_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            if (i < WARMUP) tbl[i] = '{0, 10'h3FF, 1, 0, 0, 0};
            else            tbl[i] = '{0, 10'(i - 8), 1, 1, i - 8, i - 8};
        end
        reset = 1; y = 0; dout_ready = 0;
        reset4 = 1; y4 = 0; ready4 = 0;

        // Completion on the N_OUT=4 instance while the main one sits in reset
        step();
        reset4 = 0; ready4 = 1; y4 = 10'h3FF;
        for (int i = 0; i < WARMUP; i++) begin
            step();
            chk("c4_warm_count", count4, 0);
        end
        y4 = 10'h200;
        for (int i = 0; i < 4; i++) step();
        chk("c4_count", count4, 4);
        chk("c4_checksum", checksum4, 16'h0800);
        chk("c4_done_early", done4, 0);
        y4 = 10'h3FF;
        step();
        chk("c4_done", done4, 1);
        chk("c4_valid", valid4, 0);
        for (int i = 0; i < 3; i++) begin
            y4 = 10'($urandom_range(0, 1023));
            step();
        end
        chk("c4_count_hold", count4, 4);
        chk("c4_done_hold", done4, 1);
        chk("c4_overflow", overflow4, 0);

        // Reset state, warm-up and streaming
        reset = 1; step(); step();
        chk("rst_valid", dout_valid, 0);
        chk("rst_count", count, 0);
        run_table();
        for (int k = 4; k <= 100; k++) begin
            y = 10'(k); step();
        end
        chk("s2_count", count, 100);
        chk("s2_checksum", checksum, 5050);
        chk("s2_overflow", overflow, 0);
        chk("s2_dout", dout, 100);

        // Backpressure and drop
        warm(0);
        for (int k = 1; k <= 8; k++) begin
            y = 10'(k); step();
            chk("bp_dout_hold", dout, 1);
            chk("bp_count", count, k);
        end
        y = 10'd9; step();
        chk("bp_overflow", overflow, 1);
        chk("bp_count_drop", count, 8);
        dout_ready = 1;
        for (int j = 2; j <= 8; j++) begin
            y = 10'(100 + j); step();
            chk("bp_drain", dout, j);
        end

        // Full FIFO with pop on the push edge
        warm(0);
        for (int k = 1; k <= 8; k++) begin
            y = 10'(k); step();
        end
        dout_ready = 1; y = 10'd9; step();
        chk("fp_overflow", overflow, 0);
        chk("fp_count", count, 9);
        chk("fp_dout", dout, 2);

        // Mid-run reset with 5 entries queued
        warm(0);
        for (int k = 1; k <= 5; k++) begin
            y = 10'(k); step();
        end
        reset = 1; step();
        chk("mr_valid", dout_valid, 0);
        chk("mr_count", count, 0);
        chk("mr_checksum", checksum, 0);
        chk("mr_overflow", overflow, 0);
        run_table();

        // Random traffic with occasional resets
        reset = 1; step();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            y = 10'($urandom_range(0, 1023));
            dout_ready = ($urandom_range(0, 1) == 1);
            step();
        end

        // Random traffic run through to completion
        reset = 1; step(); reset = 0;
        for (int blk = 0; blk < 11; blk++) begin
            int thresh = int'($urandom_range(15, 100));
            for (int i = 0; i < 200; i++) begin
                y = 10'($urandom_range(0, 1023));
                dout_ready = ($urandom_range(0, 99) < thresh);
                step();
            end
        end
        dout_ready = 1;
        for (int i = 0; i < 12; i++) step();
        chk("rnd_done", done, 1);
        chk("rnd_valid", dout_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
